// File: rtl/arch_restore_ctrl.sv
// arch_restore_ctrl: misprediction recovery sequencer.
// Copies the architectural map table into the rename map table in
// COPY_WIDTH-entry chunks. Retire is held and dispatch is stalled for the
// whole sequence, so the architectural table stays stable while it is copied.
//
// Restore handshake (valid/ready):
//   A chunk transfers on a rising clock edge where restore_valid and
//   restore_ready are both 1. restore_valid depends only on state, never on
//   restore_ready, and once raised it stays high with restore_base and
//   restore_data unchanged until that chunk has transferred. restore_ready
//   may toggle freely; a low cycle simply extends the copy by one cycle.
module arch_restore_ctrl #(
    parameter int N_ARCH_REG      = 32,
    parameter int N_PHYS_REG_BITS = 6,
    parameter int COPY_WIDTH      = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  mispredict_valid,
    input  logic [N_ARCH_REG*N_PHYS_REG_BITS-1:0] arch_maptable,
    input  logic                                  restore_ready,
    output logic                                  restore_valid,
    output logic [$clog2(N_ARCH_REG)-1:0]         restore_base,
    output logic [COPY_WIDTH*N_PHYS_REG_BITS-1:0] restore_data,
    output logic                                  restore_done,
    output logic                                  busy,
    output logic                                  dispatch_stall,
    output logic                                  retire_hold,
    output logic                                  overlap_err
);

    localparam int K          = N_ARCH_REG / COPY_WIDTH;
    localparam int CBITS      = (K > 1) ? $clog2(K) : 1;
    localparam int ABITS      = $clog2(N_ARCH_REG);
    localparam int CHUNK_BITS = COPY_WIDTH * N_PHYS_REG_BITS;
    localparam logic [CBITS-1:0] LAST_CHUNK = CBITS'(K - 1);

    // SETTLE gives the mispredicting branch's own retire one cycle to land
    // in the architectural table before the first chunk is read.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COPY   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // state is kept as a named, typed signal so checkers can bind to it.
    state_t           state;
    logic [CBITS-1:0] chunk_cnt;
    logic             busy_r;
    logic             valid_r;
    logic             done_r;
    logic             overlap_r;

    // Sequencer FSM with registered status flags that track the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            chunk_cnt <= '0;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            done_r    <= 1'b0;
            overlap_r <= 1'b0;
        end else begin
            // A mispredict arriving mid-recovery is dropped but remembered.
            if (mispredict_valid && (state != IDLE)) begin
                overlap_r <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (mispredict_valid) begin
                        state  <= SETTLE;
                        busy_r <= 1'b1;
                    end
                end
                SETTLE: begin
                    state   <= COPY;
                    valid_r <= 1'b1;
                end
                COPY: begin
                    if (restore_ready) begin
                        if (chunk_cnt == LAST_CHUNK) begin
                            state     <= DONE;
                            chunk_cnt <= '0;
                            valid_r   <= 1'b0;
                            done_r    <= 1'b1;
                        end else begin
                            chunk_cnt <= chunk_cnt + CBITS'(1);
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    chunk_cnt <= '0;
                    busy_r    <= 1'b0;
                    valid_r   <= 1'b0;
                    done_r    <= 1'b0;
                end
            endcase
        end
    end

    // Chunk window: base index and tags, forced to zero outside COPY.
    always_comb begin
        restore_base = '0;
        restore_data = '0;
        if (valid_r) begin
            restore_base = ABITS'(int'(chunk_cnt) * COPY_WIDTH);
            restore_data = arch_maptable[int'(chunk_cnt)*CHUNK_BITS +: CHUNK_BITS];
        end
    end

    assign restore_valid  = valid_r;
    assign restore_done   = done_r;
    assign busy           = busy_r;
    assign dispatch_stall = busy_r;
    assign retire_hold    = busy_r;
    assign overlap_err    = overlap_r;

endmodule

// File: doc/arch_restore_ctrl.md
Name: arch_restore_ctrl

Overview:
- Sequences misprediction recovery: copies the architectural map table into the speculative (rename) map table in COPY_WIDTH-entry chunks, one chunk per accepted cycle.
- Holds retire and stalls dispatch for the whole sequence.
- Sits between the retire stage, the architectural map table (read side) and the rename map table (restore write port).

Parameters:
- N_ARCH_REG, 32, architectural registers / map table entries.
- N_PHYS_REG_BITS, 6, width of a physical register tag.
- COPY_WIDTH, 8, entries restored per accepted cycle; must divide N_ARCH_REG; K = N_ARCH_REG/COPY_WIDTH chunks.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- mispredict_valid  in  1  mispredicted branch retires this cycle.
- arch_maptable  in  N_ARCH_REG*N_PHYS_REG_BITS  current architectural map table.
- restore_ready  in  1  rename map table accepts a restore chunk this cycle.
- restore_valid  out  1  restore chunk is presented.
- restore_base  out  clog2(N_ARCH_REG)  first arch index of the chunk.
- restore_data  out  COPY_WIDTH*N_PHYS_REG_BITS  tags for entries restore_base .. restore_base+COPY_WIDTH-1.
- restore_done  out  1  one-cycle pulse: the rename table is fully restored.
- busy  out  1  recovery in progress.
- dispatch_stall  out  1  dispatch must not rename.
- retire_hold  out  1  retire must not commit.
- overlap_err  out  1  sticky: mispredict_valid was seen while busy.

Behaviour:
- Asynchronous active-low reset forces state IDLE, chunk counter 0 and overlap_err 0. All outputs read 0 during reset.
- State register, chunk counter and overlap_err update only on the rising clock edge.
- States: IDLE, SETTLE, COPY, DONE.
  - IDLE -> SETTLE when mispredict_valid=1.
  - SETTLE -> COPY unconditionally. SETTLE lasts one cycle so the arch table includes the branch's own retire.
  - COPY -> COPY while restore_ready=0: counter and outputs hold.
  - COPY with restore_ready=1 and counter<K-1: counter increments.
  - COPY with restore_ready=1 and counter=K-1: go to DONE, counter clears to 0.
  - DONE -> IDLE unconditionally.
- busy = dispatch_stall = retire_hold = (state != IDLE). These decode from state, so they are glitch-free and have no input-to-output combinational path.
- restore_valid = (state == COPY).
- restore_base = counter*COPY_WIDTH, zero outside COPY.
- restore_data = arch_maptable[restore_base +: COPY_WIDTH], read combinationally. The table is stable because retire_hold=1. Data is zero outside COPY.
- A chunk transfers when restore_valid & restore_ready are both 1. restore_valid never drops while a chunk is pending.
- restore_done = (state == DONE): exactly one cycle per recovery.
- Latency with restore_ready tied to 1, mispredict at cycle 0:
  - SETTLE at cycle 1; COPY at cycles 2..K+1; DONE at cycle K+2; IDLE at K+3.
  - With K=4: busy is high for cycles 1-6 and restore_done pulses at cycle 6.
- Each cycle restore_ready is low extends COPY by one cycle.
- mispredict_valid while state != IDLE:
  - ignored; the sequence is not restarted;
  - overlap_err sets to 1 and stays set until reset.
- mispredict_valid in the same cycle as the DONE state is also ignored and flagged.
- A new recovery can start from IDLE at cycle K+3 at the earliest.
- Reset mid-sequence: immediate return to IDLE, all outputs 0, no restore_done pulse. The partially restored table is the consumer's concern.
- The counter never exceeds K-1; no wrap-around past the last chunk.

Test Plan:
1. Reset low then high, idle inputs -> all outputs 0 for 10 cycles.
2. arch_maptable[i]=i+32, mispredict at cycle 0, restore_ready=1 -> valid at cycles 2-5 with base 0, 8, 16, 24 and data 32..39, 40..47, 48..55, 56..63; restore_done at cycle 6; busy cycles 1-6.
3. Same as scenario 2 but restore_ready=0 at cycles 3 and 4 -> base 8 is held for cycles 3-5; restore_done at cycle 8; busy cycles 1-8.
4. Second mispredict_valid at cycle 3 -> sequence unchanged, overlap_err=1 from cycle 4, still 1 after 20 idle cycles, cleared by reset.
5. Reset asserted low at cycle 3 of a recovery -> outputs 0 immediately (asynchronous); no restore_done; a new mispredict restarts at base 0.
6. Back-to-back: second mispredict at cycle 7 (IDLE) -> accepted, overlap_err stays 0, second restore_done at cycle 13.
